// File: rtl/ext_pkg.sv
// Shared definitions for the extend-and-align stage: mode encoding, default widths
// and the alignment-check helper.
package ext_pkg;

  localparam int EXT_DATA_W = 32;
  localparam int EXT_IMM_W  = 16;

  typedef enum logic [2:0] {
    EXT_SEXT_IMM = 3'b000,
    EXT_ZEXT_IMM = 3'b001,
    EXT_LB       = 3'b010,
    EXT_LBU      = 3'b011,
    EXT_LH       = 3'b100,
    EXT_LHU      = 3'b101,
    EXT_LW       = 3'b110,
    EXT_LUI      = 3'b111
  } ext_mode_e;

  // Only the two low offset bits matter: halfwords need off[0]=0, words off[1:0]=0.
  function automatic logic is_misaligned(input ext_mode_e mode, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (mode)
      EXT_LH, EXT_LHU: mis = off[0];
      EXT_LW:          mis = (off != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ext_align_core.sv
// Combinational lane select, sign/zero extension and error generation.
// Optional feature: EXT_LUI_EN enables mode 111 (upper-immediate formation).
module ext_align_core
  import ext_pkg::*;
#(
  parameter int DATA_W = EXT_DATA_W,
  parameter int IMM_W  = EXT_IMM_W,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [2:0]        mode_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  ext_mode_e                mode;
  logic [7:0]               byte_v;
  logic [15:0]              half_v;
  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [31:0]       word_s;
  logic signed [IMM_W-1:0]  imm_s;
  logic [DATA_W-1:0]        res;
  logic                     illegal;

  assign mode = ext_mode_e'(mode_i);

  always_comb begin
    byte_v = '0;
    half_v = '0;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (off_i == i[OFF_W-1:0]) byte_v = data_i[8*i +: 8];
    end
    // Halfword lanes are selected by off[OFF_W-1:1]; an odd offset is flagged as an error.
    for (int i = 0; i < DATA_W/16; i++) begin
      if (off_i[OFF_W-1:1] == i[OFF_W-2:0]) half_v = data_i[16*i +: 16];
    end
  end

  assign byte_s = byte_v;
  assign half_s = half_v;
  assign word_s = data_i[31:0];
  assign imm_s  = data_i[IMM_W-1:0];

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (mode)
      EXT_SEXT_IMM: res = DATA_W'(imm_s);
      EXT_ZEXT_IMM: res = DATA_W'(data_i[IMM_W-1:0]);
      EXT_LB:       res = DATA_W'(byte_s);
      EXT_LBU:      res = DATA_W'(byte_v);
      EXT_LH:       res = DATA_W'(half_s);
      EXT_LHU:      res = DATA_W'(half_v);
      EXT_LW:       res = DATA_W'(word_s);
`ifdef EXT_LUI_EN
      EXT_LUI:      res = {data_i[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};
`endif
      default:      illegal = 1'b1;
    endcase
  end

  assign err_o  = illegal | is_misaligned(mode, off_i[1:0]);
  assign data_o = err_o ? '0 : res;

endmodule

// File: rtl/ext_align_unit.sv
// Registered extend-and-align stage with valid/ready handshakes and a two-entry
// (output + skid) buffer. Optional feature: EXT_LUI_EN (see ext_align_core).
module ext_align_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = EXT_DATA_W,
  parameter int IMM_W  = EXT_IMM_W,
  parameter int OFF_W  = $clog2(DATA_W/8)   // derived, leave at default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [DATA_W-1:0] res_data;
  logic              res_err;

  logic              or_valid_q, or_valid_d;
  logic [DATA_W-1:0] or_data_q,  or_data_d;
  logic              or_err_q,   or_err_d;
  logic              sr_valid_q, sr_valid_d;
  logic [DATA_W-1:0] sr_data_q,  sr_data_d;
  logic              sr_err_q,   sr_err_d;

  logic accept;
  logic drain;

  ext_align_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .OFF_W  (OFF_W)
  ) u_core (
    .mode_i (in_mode),
    .off_i  (in_off),
    .data_i (in_data),
    .data_o (res_data),
    .err_o  (res_err)
  );

  // Registered ready: never depends combinationally on out_ready.
  assign in_ready = !sr_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = or_valid_q && out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_err_d   = or_err_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    sr_err_d   = sr_err_q;
    if (drain) begin
      // accept cannot coincide with a full SR, so a refill from SR loses nothing
      if (sr_valid_q) begin
        or_data_d  = sr_data_q;
        or_err_d   = sr_err_q;
        sr_valid_d = 1'b0;
      end else if (accept) begin
        or_data_d  = res_data;
        or_err_d   = res_err;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = res_data;
        or_err_d   = res_err;
      end else begin
        sr_valid_d = 1'b1;
        sr_data_d  = res_data;
        sr_err_d   = res_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_err_q   <= 1'b0;
      sr_valid_q <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_err_q   <= or_err_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  // Skid payload is only meaningful while sr_valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    sr_data_q <= sr_data_d;
    sr_err_q  <= sr_err_d;
  end

  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_err   = or_err_q;

endmodule

// File: tb/tb_ext_align_unit.sv
// Self-checking bench for ext_align_unit: directed cases plus a randomized run
// checked against a FIFO-occupancy and arithmetic reference model.
module tb_ext_align_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [1:0]  in_off;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int tests;
  int fails;

  localparam longint TWO31 = 64'd2147483648;
  localparam longint TWO32 = 64'd4294967296;

  ext_align_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_off    (in_off),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, data} computed with plain integer arithmetic.
  function automatic logic [32:0] ref_model(input int mode, input int off, input logic [31:0] d);
    longint u, imm, b, h, v;
    bit err;
    u   = longint'(d);
    imm = u % 65536;
    b   = (u >> (8*off)) % 256;
    h   = (u >> (8*off)) % 65536;
    v   = 0;
    err = 0;
    case (mode)
      0: v = (imm >= 32768) ? imm - 65536 : imm;
      1: v = imm;
      2: v = (b >= 128) ? b - 256 : b;
      3: v = b;
      4: if (off % 2 != 0) err = 1; else v = (h >= 32768) ? h - 65536 : h;
      5: if (off % 2 != 0) err = 1; else v = h;
      6: if (off != 0) err = 1; else v = (u >= TWO31) ? u - TWO32 : u;
      default: begin
`ifdef EXT_LUI_EN
        v = imm * 65536;
`else
        err = 1;
`endif
      end
    endcase
    if (err) return {1'b1, 32'h0};
    return {1'b0, v[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int m, input int o, input logic [31:0] d);
    in_valid = 1'b1;
    in_mode  = 3'(m);
    in_off   = 2'(o);
    in_data  = d;
  endtask

  task automatic send(input int m, input int o, input logic [31:0] d);
    present(m, o, d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = '0; in_off = '0; in_data = '0;
    tick(); tick();
    tests++;
    if ({out_valid, in_ready, out_err, out_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b rdy=%b err=%b d=%h exp v=0 rdy=1 err=0 d=0",
               out_valid, in_ready, out_err, out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    send(0, 3, 32'h5A5A_8001);
    tests++;
    if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 32'hFFFF8001}) begin
      fails++;
      $display("FAIL sext_imm: got v=%b err=%b d=%h exp v=1 err=0 d=ffff8001", out_valid, out_err, out_data);
    end
    send(1, 1, 32'h5A5A_8001);
    tests++;
    if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 32'h00008001}) begin
      fails++;
      $display("FAIL zext_imm: got v=%b err=%b d=%h exp v=1 err=0 d=00008001", out_valid, out_err, out_data);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL imm_drain: got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_load();
    logic [32:0] exp_v [3];
    int          md [3];
    int          of [3];
    exp_v[0] = {1'b0, 32'hFFFFFFFF}; md[0] = 2; of[0] = 0;
    exp_v[1] = {1'b0, 32'h0000007F}; md[1] = 2; of[1] = 2;
    exp_v[2] = {1'b0, 32'h00000080}; md[2] = 3; of[2] = 3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(md[i], of[i], 32'h807F_00FF);
      tests++;
      if ({out_valid, out_err, out_data} !== {1'b1, exp_v[i]}) begin
        fails++;
        $display("FAIL load_byte[%0d]: got v=%b err=%b d=%h exp err=%b d=%h",
                 i, out_valid, out_err, out_data, exp_v[i][32], exp_v[i][31:0]);
      end
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [32:0] exp_v [4];
    int          md [4];
    int          of [4];
    logic [31:0] dv [4];
    exp_v[0] = {1'b1, 32'h0};        md[0] = 4; of[0] = 1; dv[0] = 32'hFFFF_FFFF;
    exp_v[1] = {1'b0, 32'h0000BEEF}; md[1] = 5; of[1] = 2; dv[1] = 32'hBEEF_1234;
    exp_v[2] = {1'b1, 32'h0};        md[2] = 6; of[2] = 2; dv[2] = 32'h1234_5678;
    exp_v[3] = {1'b0, 32'hFFFFBEEF}; md[3] = 4; of[3] = 2; dv[3] = 32'hBEEF_1234;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(md[i], of[i], dv[i]);
      tests++;
      if ({out_valid, out_err, out_data} !== {1'b1, exp_v[i]}) begin
        fails++;
        $display("FAIL align[%0d]: got v=%b err=%b d=%h exp err=%b d=%h",
                 i, out_valid, out_err, out_data, exp_v[i][32], exp_v[i][31:0]);
      end
    end
    tick();
  endtask

  task automatic test_lui();
    logic [32:0] exp_v;
`ifdef EXT_LUI_EN
    exp_v = {1'b0, 32'h12340000};
`else
    exp_v = {1'b1, 32'h0};
`endif
    out_ready = 1'b1;
    send(7, 2, 32'hFFFF_1234);
    tests++;
    if ({out_valid, out_err, out_data} !== {1'b1, exp_v}) begin
      fails++;
      $display("FAIL lui: got v=%b err=%b d=%h exp err=%b d=%h",
               out_valid, out_err, out_data, exp_v[32], exp_v[31:0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] da, db, dc;
    logic [32:0] ea, eb, ec;
    da = $urandom; db = $urandom; dc = $urandom;
    ea = ref_model(2, 1, da); eb = ref_model(5, 0, db); ec = ref_model(0, 0, dc);
    out_ready = 1'b0;
    present(2, 1, da);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy_a: got %b exp 1", in_ready); end
    tick();
    present(5, 0, db);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy_b: got %b exp 1", in_ready); end
    tick();
    present(0, 0, dc);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_rdy_c: got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, out_err, out_data} !== {1'b1, ea}) begin
        fails++;
        $display("FAIL b2b_hold_a[%0d]: got v=%b err=%b d=%h exp err=%b d=%h",
                 i, out_valid, out_err, out_data, ea[32], ea[31:0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({in_ready, out_valid, out_err, out_data} !== {2'b11, eb}) begin
      fails++;
      $display("FAIL b2b_out_b: got rdy=%b v=%b err=%b d=%h exp rdy=1 err=%b d=%h",
               in_ready, out_valid, out_err, out_data, eb[32], eb[31:0]);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out_err, out_data} !== {1'b1, ec}) begin
      fails++;
      $display("FAIL b2b_out_c: got v=%b err=%b d=%h exp err=%b d=%h",
               out_valid, out_err, out_data, ec[32], ec[31:0]);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    present(3, 0, 32'h11);
    tick();
    present(3, 1, 32'h2200);
    tick();
    in_valid = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b01) begin
      fails++;
      $display("FAIL rst_mid_full: got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, out_err, out_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL rst_mid_clear: got v=%b rdy=%b err=%b d=%h exp v=0 rdy=1 err=0 d=0",
               out_valid, in_ready, out_err, out_data);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3, 1, 32'h0000_AB00);
    tests++;
    if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 32'h000000AB}) begin
      fails++;
      $display("FAIL rst_mid_first: got v=%b err=%b d=%h exp v=1 err=0 d=000000ab", out_valid, out_err, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    int          m, o;
    logic [31:0] d;
    bit          acc, drn;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tests++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        fails++;
        $display("FAIL rand_flags[%0d]: got v=%b rdy=%b exp occupancy=%0d", cyc, out_valid, in_ready, q.size());
      end else if (q.size() != 0) begin
        tests++;
        if ({out_err, out_data} !== q[0]) begin
          fails++;
          $display("FAIL rand_data[%0d]: got err=%b d=%h exp err=%b d=%h",
                   cyc, out_err, out_data, q[0][32], q[0][31:0]);
        end
      end
      m = int'($urandom_range(0, 7));
      o = int'($urandom_range(0, 3));
      d = $urandom;
      in_mode   = 3'(m);
      in_off    = 2'(o);
      in_data   = d;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() != 0);
      tick();
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_model(m, o, d));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_imm();
    test_load();
    test_misalign();
    test_lui();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
